// File: rtl/mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access : memory stage with req/ack data-memory handshake, pipeline  |
// |              stall, timeout/misalignment error and branch select.        |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module mem_access #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MemRead_M,
  input  logic         MemWrite_M,
  input  logic         Branch_M,
  input  logic         zero_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_out,
  output logic [N-1:0] readData_M,
  output logic         stall_M,
  output logic         err_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          dm_req_q;
  logic          dm_we_q;
  logic [N-1:0]  dm_addr_q;
  logic [N-1:0]  dm_wdata_q;
  logic [N-1:0]  rdata_q;
  logic          err_q;

  logic w_access;
  logic w_misaligned;

  assign w_access     = MemRead_M | MemWrite_M;
  assign w_misaligned = |aluResult_M[2:0];

  assign PCSrc_M      = Branch_M & zero_M;
  assign PCBranch_out = PCBranch_M;
  // DONE deliberately releases the stall so the finished instruction advances once.
  assign stall_M      = ((state_q == IDLE) & w_access) | (state_q == BUSY);

  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign readData_M = rdata_q;
  assign err_M      = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_access) begin
            if (w_misaligned) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= DONE;
            end else begin
              dm_addr_q  <= aluResult_M;
              dm_wdata_q <= writeData_M;
              dm_we_q    <= MemWrite_M;
              dm_req_q   <= 1'b1;
              cnt_q      <= '0;
              state_q    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dm_ack) begin
            dm_req_q <= 1'b0;
            if (!dm_we_q) begin
              rdata_q <= dm_rdata;
            end
            state_q <= DONE;
          end else if (cnt_q == C_LAST) begin
            dm_req_q <= 1'b0;
            err_q    <= 1'b1;
            rdata_q  <= '0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
